power_domain_sequencer: RTL and testbench
=========================================

// Module: power_domain_sequencer
// PURPOSE
//  Sequences power-down and power-up of one switchable domain (GPRs, instruction decoder, multiplier or mem X/Y).
//  One instance per domain, placed under the power controller.
//  Orders isolation, state save, switch, reset, restore and de-isolation.
//  Waits on the power-switch acknowledge, with a timeout.
//  Returns a one-cycle completion ack.
// PARAMETERS
//  ISO_SETUP   2   cycles iso is held before save/switch-off; also before iso drops on wake (>=1)
//  RST_HOLD    4   cycles dom_reset is asserted after switch-on (>=1)
//  SW_TIMEOUT  16  max cycles to wait for sw_ack to reach its target level (>=2)
//  CNT_W       5   width of the internal counter; must hold max(ISO_SETUP,RST_HOLD,SW_TIMEOUT)
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  down_req    in   1  power-down request, level; sampled only in ACTIVE
//  up_req      in   1  power-up request, level; sampled only in OFF
//  err_clr     in   1  clears a fault; sampled only in FAULT
//  sw_ack      in   1  power-switch status: 1 = domain rail off
//  iso         out  1  domain output isolation enable
//  save        out  1  retention save strobe, 1 cycle
//  restore     out  1  retention restore strobe, 1 cycle
//  sd          out  1  power-switch shutdown: 1 = rail off
//  dom_reset   out  1  domain reset, active-high
//  power_ack   out  1  one-cycle pulse when a sequence completes
//  busy        out  1  high in every state except ACTIVE, OFF and FAULT
//  err         out  1  sticky switch-timeout flag
// BEHAVIOUR
//  Reset: state=ACTIVE, cnt=0, and every output is 0. Reset takes effect immediately at any point, including mid-sequence.
//  Outputs are registered and decoded from the state; an output changes on the edge that enters a state.
//  cnt is loaded on state entry and decrements once per cycle.
//  States and transitions:
//   ACTIVE:  iso=0, sd=0. down_req=1 -> ISO_DN. up_req is ignored.
//   ISO_DN:  iso=1 for ISO_SETUP cycles -> SAVE.
//   SAVE:    save=1 for exactly 1 cycle -> SW_OFF.
//   SW_OFF:  iso=1, sd=1. sw_ack=1 -> OFF. SW_TIMEOUT cycles without ack -> FAULT.
//   OFF:     iso=1, sd=1. Entering OFF pulses power_ack. up_req=1 -> SW_ON. down_req is ignored.
//   SW_ON:   sd=0, iso=1, dom_reset=1. sw_ack=0 -> RST. Timeout -> FAULT.
//   RST:     dom_reset=1 for RST_HOLD cycles, iso=1 -> RESTORE.
//   RESTORE: restore=1 for 1 cycle, iso=1 -> ISO_UP.
//   ISO_UP:  iso=1 for ISO_SETUP cycles -> ACTIVE, pulsing power_ack on entry.
//   FAULT:   err=1, iso=1, dom_reset=1, sd keeps its value from the failing state.
//            err_clr=1 -> SW_ON (recovery wake); err stays set until ACTIVE is re-entered.
//  Requests arriving mid-sequence are ignored, not queued. A level request still held at completion is acted on the cycle after ACTIVE/OFF is entered.
//  down_req and up_req both high: only the request valid in the current state is honoured.
//  sw_ack already at its target level on the SW_OFF/SW_ON entry edge: the next state is entered the following cycle.
//  Timeout boundary: an ack arriving in the same cycle that cnt reaches 0 wins; no fault is raised.
//  Down latency, req-sample edge to sd=1: ISO_SETUP+1 cycles.
//  Up latency from the sw_ack fall: RST_HOLD+1+ISO_SETUP cycles to ACTIVE.
// CONFIGURATION
//  PDS_RETENTION_EN defined: SAVE and RESTORE states present, as described above.
//  PDS_RETENTION_EN undefined: SAVE and RESTORE are removed.
//   ISO_DN goes directly to SW_OFF; RST goes directly to ISO_UP.
//   save and restore are tied to 0; both latencies shrink by 1 cycle.
// TESTING (ISO_SETUP=2, RST_HOLD=4, SW_TIMEOUT=16, PDS_RETENTION_EN defined)
//  1. Power-down: down_req=1 at edge 0 -> iso=1 @1, save=1 @3 only, sd=1 @4.
//     sw_ack=1 @6 -> OFF @7, power_ack=1 @7 only.
//  2. Power-up from OFF: up_req=1 -> sd=0 next edge; sw_ack=0 -> dom_reset high 4 more cycles,
//     then restore 1 cycle, iso=0 and power_ack pulse 3 cycles after restore.
//  3. Switch timeout: sw_ack held 0 in SW_OFF -> FAULT 16 cycles after entry, err=1, iso=1, sd=1.
//     err_clr=1 -> SW_ON; full wake -> ACTIVE with err=0.
//  4. Async reset (reset=0) mid-RST -> all outputs 0 immediately; after release, ACTIVE with down_req=0 -> stays idle.
//  5. down_req and up_req both 1 in ACTIVE -> power-down only.
//     Keep up_req=1 -> the wake starts the cycle after OFF; power_ack pulses twice in total.
//  6. Macro undefined: repeat test 1 -> save is never 1 and sd=1 @3.

Source files
------------

// File: rtl/power_domain_sequencer_if.sv
// Handshake bundle between the power controller and one domain sequencer.
// Requests and switch status flow in on slave; sequencing controls flow out.
interface power_domain_sequencer_if;
    logic down_req;
    logic up_req;
    logic err_clr;
    logic sw_ack;
    logic iso;
    logic save;
    logic restore;
    logic sd;
    logic dom_reset;
    logic power_ack;
    logic busy;
    logic err;

    modport master (
        output down_req, up_req, err_clr, sw_ack,
        input  iso, save, restore, sd, dom_reset, power_ack, busy, err
    );

    modport slave (
        input  down_req, up_req, err_clr, sw_ack,
        output iso, save, restore, sd, dom_reset, power_ack, busy, err
    );
endinterface

// File: rtl/power_domain_sequencer.sv
// Purpose: orders iso/save/switch/reset/restore for one switchable domain (PDS_RETENTION_EN adds SAVE/RESTORE).
// Latency: down ISO_SETUP+1 cycles req->sd; up RST_HOLD+1+ISO_SETUP cycles sw_ack fall->ACTIVE (each -1 without retention).
// Backpressure: none; requests are levels sampled only in ACTIVE/OFF, mid-sequence requests are ignored.
module power_domain_sequencer #(
    parameter int ISO_SETUP  = 2,
    parameter int RST_HOLD   = 4,
    parameter int SW_TIMEOUT = 16,
    parameter int CNT_W      = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    power_domain_sequencer_if.slave        pds
);

    typedef enum logic [3:0] {
        ST_ACTIVE,
        ST_ISO_DN,
        ST_SAVE,
        ST_SW_OFF,
        ST_OFF,
        ST_SW_ON,
        ST_RST,
        ST_RESTORE,
        ST_ISO_UP,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_SETUP - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] SW_LOAD  = CNT_W'(SW_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic iso_q, save_q, restore_q, sd_q, dom_reset_q, power_ack_q, busy_q, err_q;
    logic iso_d, save_d, restore_d, sd_d, dom_reset_d, power_ack_d, busy_d, err_d;

    wire cnt_zero = (cnt == '0);

    // Next-state: switch acknowledge beats the timeout on the terminal count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACTIVE: if (pds.down_req) state_nxt = ST_ISO_DN;
`ifdef PDS_RETENTION_EN
            ST_ISO_DN:  if (cnt_zero) state_nxt = ST_SAVE;
            ST_SAVE:    state_nxt = ST_SW_OFF;
            ST_RST:     if (cnt_zero) state_nxt = ST_RESTORE;
            ST_RESTORE: state_nxt = ST_ISO_UP;
`else
            ST_ISO_DN:  if (cnt_zero) state_nxt = ST_SW_OFF;
            ST_RST:     if (cnt_zero) state_nxt = ST_ISO_UP;
`endif
            ST_SW_OFF: begin
                if (pds.sw_ack)     state_nxt = ST_OFF;
                else if (cnt_zero)  state_nxt = ST_FAULT;
            end
            ST_OFF:    if (pds.up_req) state_nxt = ST_SW_ON;
            ST_SW_ON: begin
                if (!pds.sw_ack)    state_nxt = ST_RST;
                else if (cnt_zero)  state_nxt = ST_FAULT;
            end
            ST_ISO_UP: if (cnt_zero) state_nxt = ST_ACTIVE;
            ST_FAULT:  if (pds.err_clr) state_nxt = ST_SW_ON;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

    // Counter is loaded with (duration-1) on entry and counts down to zero.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            unique case (state_nxt)
                ST_ISO_DN, ST_ISO_UP: cnt_nxt = ISO_LOAD;
                ST_SW_OFF, ST_SW_ON:  cnt_nxt = SW_LOAD;
                ST_RST:               cnt_nxt = RST_LOAD;
                default:              cnt_nxt = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Outputs are decoded from the state being entered and registered.
    always_comb begin
        iso_d       = (state_nxt != ST_ACTIVE);
`ifdef PDS_RETENTION_EN
        save_d      = (state_nxt == ST_SAVE);
        restore_d   = (state_nxt == ST_RESTORE);
`else
        save_d      = 1'b0;
        restore_d   = 1'b0;
`endif
        sd_d        = 1'b0;
        if (state_nxt == ST_SW_OFF || state_nxt == ST_OFF) sd_d = 1'b1;
        else if (state_nxt == ST_FAULT)                    sd_d = sd_q;
        dom_reset_d = (state_nxt == ST_SW_ON) || (state_nxt == ST_RST) || (state_nxt == ST_FAULT);
        power_ack_d = (state == ST_SW_OFF && state_nxt == ST_OFF) ||
                      (state == ST_ISO_UP && state_nxt == ST_ACTIVE);
        busy_d      = !(state_nxt == ST_ACTIVE || state_nxt == ST_OFF || state_nxt == ST_FAULT);
        err_d       = err_q;
        if (state_nxt == ST_FAULT)       err_d = 1'b1;
        else if (state_nxt == ST_ACTIVE) err_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_ACTIVE;
            cnt         <= '0;
            iso_q       <= 1'b0;
            save_q      <= 1'b0;
            restore_q   <= 1'b0;
            sd_q        <= 1'b0;
            dom_reset_q <= 1'b0;
            power_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            iso_q       <= iso_d;
            save_q      <= save_d;
            restore_q   <= restore_d;
            sd_q        <= sd_d;
            dom_reset_q <= dom_reset_d;
            power_ack_q <= power_ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign pds.iso       = iso_q;
    assign pds.save      = save_q;
    assign pds.restore   = restore_q;
    assign pds.sd        = sd_q;
    assign pds.dom_reset = dom_reset_q;
    assign pds.power_ack = power_ack_q;
    assign pds.busy      = busy_q;
    assign pds.err       = err_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Bench for power_domain_sequencer: vector table, corner sequences and a random run against a phase-plan model.
module tb_power_domain_sequencer;

    localparam int ISO_SETUP  = 2;
    localparam int RST_HOLD   = 4;
    localparam int SW_TIMEOUT = 16;
`ifdef PDS_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    power_domain_sequencer_if pds ();

    power_domain_sequencer #(
        .ISO_SETUP  (ISO_SETUP),
        .RST_HOLD   (RST_HOLD),
        .SW_TIMEOUT (SW_TIMEOUT),
        .CNT_W      (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pds   (pds)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // {iso, save, restore, sd, dom_reset, power_ack, busy, err}
    function automatic logic [7:0] outs();
        return {pds.iso, pds.save, pds.restore, pds.sd, pds.dom_reset, pds.power_ack, pds.busy, pds.err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] s);
        {pds.down_req, pds.up_req, pds.err_clr, pds.sw_ack} = s;
    endtask

    // Ticks until output bit idx equals val; an expired bound is a failure.
    task automatic wait_for(input string name, input int idx, input logic val, input int max);
        logic [7:0] o;
        bit hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            tick();
            o = outs();
            if (o[idx] == val) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: bit %0d never reached %b within %0d cycles", name, idx, val, max);
        end
    endtask

    // ---------------- reference model: phase plan ----------------
    localparam int P_ACTIVE = 0, P_ISO_DN = 1, P_SAVE = 2, P_SW_OFF = 3, P_OFF = 4;
    localparam int P_SW_ON = 5, P_RST = 6, P_RESTORE = 7, P_ISO_UP = 8, P_FAULT = 9;

    int m_ph, m_len, m_age;
    int plan_ph[$];
    int plan_len[$];
    bit m_sd, m_err, m_pack;

    function automatic void m_enter(int ph, int len);
        m_ph = ph; m_len = len; m_age = 0;
    endfunction

    function automatic void m_pop();
        int ph, len;
        ph  = plan_ph.pop_front();
        len = plan_len.pop_front();
        m_enter(ph, len);
    endfunction

    function automatic void m_plan(int ph, int len);
        plan_ph.push_back(ph);
        plan_len.push_back(len);
    endfunction

    function automatic void m_reset();
        plan_ph.delete(); plan_len.delete();
        m_enter(P_ACTIVE, 0);
        m_sd = 0; m_err = 0; m_pack = 0;
    endfunction

    function automatic void m_down();
        plan_ph.delete(); plan_len.delete();
        m_plan(P_ISO_DN, ISO_SETUP);
        if (RET) m_plan(P_SAVE, 1);
        m_plan(P_SW_OFF, 0);
        m_pop();
    endfunction

    function automatic void m_wake();
        plan_ph.delete(); plan_len.delete();
        m_plan(P_SW_ON, 0);
        m_plan(P_RST, RST_HOLD);
        if (RET) m_plan(P_RESTORE, 1);
        m_plan(P_ISO_UP, ISO_SETUP);
        m_plan(P_ACTIVE, 0);
        m_pop();
    endfunction

    function automatic void m_step(bit d, bit u, bit c, bit a);
        m_pack = 0;
        m_age++;
        case (m_ph)
            P_ACTIVE: if (d) m_down();
            P_OFF:    if (u) m_wake();
            P_FAULT:  if (c) m_wake();
            P_SW_OFF: begin
                if (a) begin m_enter(P_OFF, 0); m_pack = 1; end
                else if (m_age >= SW_TIMEOUT) begin m_enter(P_FAULT, 0); m_err = 1; end
            end
            P_SW_ON: begin
                if (!a) m_pop();
                else if (m_age >= SW_TIMEOUT) begin m_enter(P_FAULT, 0); m_err = 1; end
            end
            default: begin
                if (m_age >= m_len) begin
                    m_pop();
                    if (m_ph == P_ACTIVE) begin m_pack = 1; m_err = 0; end
                end
            end
        endcase
        if (m_ph == P_SW_OFF || m_ph == P_OFF) m_sd = 1;
        else if (m_ph != P_FAULT)              m_sd = 0;
    endfunction

    function automatic logic [7:0] m_exp();
        return {m_ph != P_ACTIVE, m_ph == P_SAVE, m_ph == P_RESTORE, m_sd,
                (m_ph == P_SW_ON || m_ph == P_RST || m_ph == P_FAULT), m_pack,
                !(m_ph == P_ACTIVE || m_ph == P_OFF || m_ph == P_FAULT), m_err};
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0] stim;   // {down_req, up_req, err_clr, sw_ack}
        logic [7:0] want;
    } vec_t;

    vec_t tbl [19];

    task automatic do_reset();
        drive(4'b0000);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", outs(), 8'b0000_0000);
        reset = 1'b1;
        @(negedge clock);
        m_reset();
    endtask

    int cyc_cnt;
    int acks;
    int stuck;

    initial begin
        reset = 1'b1;
        drive(4'b0000);
        #2 reset = 1'b0;
        #1 chk("async_reset_at_start", outs(), 8'b0000_0000);

        // Power-down then power-up; rows after OFF are the wake sequence.
        tbl[0]  = '{4'b1000, 8'b1000_0010};
        tbl[1]  = '{4'b0000, 8'b1000_0010};
        tbl[2]  = '{4'b0000, RET ? 8'b1100_0010 : 8'b1001_0010};
        tbl[3]  = '{4'b0000, 8'b1001_0010};
        tbl[4]  = '{4'b0000, 8'b1001_0010};
        tbl[5]  = '{4'b0000, 8'b1001_0010};
        tbl[6]  = '{4'b0001, 8'b1001_0100};
        tbl[7]  = '{4'b0001, 8'b1001_0000};
        tbl[8]  = '{4'b0101, 8'b1000_1010};
        tbl[9]  = '{4'b0001, 8'b1000_1010};
        tbl[10] = '{4'b0000, 8'b1000_1010};
        tbl[11] = '{4'b0000, 8'b1000_1010};
        tbl[12] = '{4'b0000, 8'b1000_1010};
        tbl[13] = '{4'b0000, 8'b1000_1010};
        tbl[14] = '{4'b0000, RET ? 8'b1010_0010 : 8'b1000_0010};
        tbl[15] = '{4'b0000, 8'b1000_0010};
        tbl[16] = '{4'b0000, RET ? 8'b1000_0010 : 8'b0000_0100};
        tbl[17] = '{4'b0000, RET ? 8'b0000_0100 : 8'b0000_0000};
        tbl[18] = '{4'b0000, 8'b0000_0000};

        @(negedge clock);
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].stim);
            tick();
            chk($sformatf("vec%0d", i + 1), outs(), tbl[i].want);
        end

        // Switch timeout in SW_OFF, then recovery wake.
        drive(4'b1000); tick(); drive(4'b0000);
        wait_for("reach_sw_off", 4, 1'b1, 10);
        cyc_cnt = 0;
        while (!pds.err && cyc_cnt < 40) begin tick(); cyc_cnt++; end
        chk("timeout_cycles", cyc_cnt, SW_TIMEOUT);
        chk("fault_outputs", outs(), 8'b1001_1001);
        drive(4'b0010); tick(); drive(4'b0000);
        chk("fault_clr_sw_on", outs(), 8'b1000_1011);
        wait_for("recovery_ack", 2, 1'b1, 30);
        chk("recovered_active", outs(), 8'b0000_0100);

        // Ack on the terminal count cycle wins over the timeout.
        drive(4'b1000); tick(); drive(4'b0000);
        wait_for("reach_sw_off2", 4, 1'b1, 10);
        repeat (SW_TIMEOUT - 1) tick();
        drive(4'b0001); tick();
        chk("ack_at_boundary", outs(), 8'b1001_0100);
        drive(4'b0101); tick(); drive(4'b0000);
        wait_for("boundary_wake_ack", 2, 1'b1, 30);

        // Asynchronous reset in the middle of RST.
        drive(4'b1000); tick(); drive(4'b0000);
        wait_for("reach_sw_off3", 4, 1'b1, 10);
        drive(4'b0001); tick();
        drive(4'b0101); tick();
        drive(4'b0000); tick(); tick();
        chk("in_rst", outs(), 8'b1000_1010);
        reset = 1'b0;
        #1 chk("reset_mid_rst", outs(), 8'b0000_0000);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        repeat (5) tick();
        chk("idle_after_reset", outs(), 8'b0000_0000);

        // Both requests in ACTIVE: down only; held up_req wakes right after OFF.
        drive(4'b1100); tick();
        chk("both_req_down", outs(), 8'b1000_0010);
        acks = 0;
        drive(4'b0100);
        cyc_cnt = 0;
        while (!pds.power_ack && cyc_cnt < 20) begin
            pds.sw_ack = pds.sd; tick(); cyc_cnt++;
        end
        chk("both_off_ack", outs(), 8'b1001_0100);
        if (pds.power_ack) acks++;
        tick();
        chk("wake_next_cycle", outs(), 8'b1000_1010);
        pds.sw_ack = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (pds.power_ack) acks++;
        end
        chk("ack_pulse_count", acks, 2);
        chk("active_with_up_held", outs(), 8'b0000_0000);
        drive(4'b0000);

        // Randomized run against the phase-plan model.
        do_reset();
        stuck = 0;
        for (int c = 0; c < 2000 && n_fail < 20; c++) begin
            pds.down_req = ($urandom_range(0, 3) == 0);
            pds.up_req   = ($urandom_range(0, 3) == 0);
            pds.err_clr  = ($urandom_range(0, 4) == 0);
            if (stuck > 0) stuck--;
            else if ($urandom_range(0, 59) == 0) stuck = $urandom_range(10, 25);
            else if ($urandom_range(0, 9) < 7) pds.sw_ack = pds.sd;
            m_step(pds.down_req, pds.up_req, pds.err_clr, pds.sw_ack);
            tick();
            chk("random", outs(), m_exp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
